// File: rtl/tof_poll_sequencer.sv
// rtl/tof_poll_sequencer.sv - VL53L0X single-shot range sequencer over shared I2C read/write engines
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   trigger                     start one measurement (honoured only when idle)
//   busy, state_out             sequencer activity / debug state
//   dev_address                 constant device address for both engines
//   rd_start/rd_reg_address/rd_byte_width, rd_done/rd_failure   read engine handshake
//   rd_fifo_read_en/rd_fifo_data/rd_fifo_empty/rd_fifo_read_valid read engine byte FIFO
//   wr_start/wr_reg_address/wr_data, wr_done/wr_failure          write engine handshake
//   i2c_owner                   master mux select: 0 = read engine, 1 = write engine
//   range_mm, range_valid       last good range and its update pulse
//   error, error_count          aborted-measurement pulse and saturating count
module tof_poll_sequencer #(
  parameter logic [6:0] DEV_ADDR           = 7'h29,
  parameter logic [7:0] REG_SYSRANGE_START = 8'h00,
  parameter logic [7:0] REG_INT_STATUS     = 8'h13,
  parameter logic [7:0] REG_RANGE_RESULT   = 8'h1E,
  parameter logic [7:0] REG_INT_CLEAR      = 8'h0B,
  parameter int         POLL_LIMIT         = 64,
  parameter int         WATCHDOG           = 2700000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  output logic        busy,
  output logic [6:0]  dev_address,
  output logic        rd_start,
  output logic [7:0]  rd_reg_address,
  output logic [3:0]  rd_byte_width,
  input  logic        rd_done,
  input  logic        rd_failure,
  output logic        rd_fifo_read_en,
  input  logic [7:0]  rd_fifo_data,
  input  logic        rd_fifo_empty,
  input  logic        rd_fifo_read_valid,
  output logic        wr_start,
  output logic [7:0]  wr_reg_address,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_failure,
  output logic        i2c_owner,
  output logic [15:0] range_mm,
  output logic        range_valid,
  output logic        error,
  output logic [7:0]  error_count,
  output logic [3:0]  state_out
);

  localparam int              WD_W     = $clog2(WATCHDOG + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WATCHDOG - 1);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  localparam logic [7:0]      POLL_MAX = 8'(POLL_LIMIT);

  typedef enum logic [3:0] {
    IDLE, W_START, W_START_WAIT, R_STAT, R_STAT_WAIT, POP_STAT, CHK_STAT,
    R_RANGE, R_RANGE_WAIT, POP_HI, POP_LO, W_CLR, W_CLR_WAIT, PUBLISH
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      poll_q, poll_d;
  logic            pop_pend_q, pop_pend_d;
  logic [2:0]      stat_q, stat_d;
  logic [7:0]      hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d, rd_start_q, rd_start_d, wr_start_q, wr_start_d;
  logic            rd_pop_q, rd_pop_d, owner_q, owner_d;
  logic [7:0]      rd_reg_q, rd_reg_d, wr_reg_q, wr_reg_d, wr_data_q, wr_data_d;
  logic [3:0]      rd_width_q, rd_width_d;
  logic [15:0]     range_q, range_d;
  logic            range_valid_q, range_valid_d, error_q, error_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            fail, pop_got, wd_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      poll_q        <= '0;
      pop_pend_q    <= 1'b0;
      stat_q        <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      busy_q        <= 1'b0;
      rd_start_q    <= 1'b0;
      wr_start_q    <= 1'b0;
      rd_pop_q      <= 1'b0;
      owner_q       <= 1'b0;
      rd_reg_q      <= '0;
      rd_width_q    <= '0;
      wr_reg_q      <= '0;
      wr_data_q     <= '0;
      range_q       <= '0;
      range_valid_q <= 1'b0;
      error_q       <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      poll_q        <= poll_d;
      pop_pend_q    <= pop_pend_d;
      stat_q        <= stat_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      busy_q        <= busy_d;
      rd_start_q    <= rd_start_d;
      wr_start_q    <= wr_start_d;
      rd_pop_q      <= rd_pop_d;
      owner_q       <= owner_d;
      rd_reg_q      <= rd_reg_d;
      rd_width_q    <= rd_width_d;
      wr_reg_q      <= wr_reg_d;
      wr_data_q     <= wr_data_d;
      range_q       <= range_d;
      range_valid_q <= range_valid_d;
      error_q       <= error_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wd_d          = '0;          // watchdog restarts whenever a wait is left or not counting
    poll_d        = poll_q;
    pop_pend_d    = 1'b0;
    stat_d        = stat_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    rd_start_d    = 1'b0;
    wr_start_d    = 1'b0;
    rd_pop_d      = 1'b0;
    owner_d       = owner_q;
    rd_reg_d      = rd_reg_q;
    rd_width_d    = rd_width_q;
    wr_reg_d      = wr_reg_q;
    wr_data_d     = wr_data_q;
    range_d       = range_q;
    range_valid_d = 1'b0;
    error_d       = 1'b0;
    err_cnt_d     = err_cnt_q;
    fail          = 1'b0;
    pop_got       = 1'b0;
    wd_expired    = (wd_q == WD_LAST);

    // Shared FIFO pop handshake: one registered pop strobe, then wait for the
    // valid byte. The watchdog covers both the empty wait and the valid wait.
    if (state_q == POP_STAT || state_q == POP_HI || state_q == POP_LO) begin
      if (pop_pend_q) begin
        if (rd_fifo_read_valid) begin
          pop_got = 1'b1;
        end else if (wd_expired) begin
          fail = 1'b1;
        end else begin
          pop_pend_d = 1'b1;
          wd_d       = wd_q + WD_ONE;
        end
      end else if (!rd_fifo_empty) begin
        rd_pop_d   = 1'b1;
        pop_pend_d = 1'b1;
      end else if (wd_expired) begin
        fail = 1'b1;
      end else begin
        wd_d = wd_q + WD_ONE;
      end
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = W_START;
          poll_d  = '0;
        end
      end
      W_START: begin
        owner_d    = 1'b1;
        wr_reg_d   = REG_SYSRANGE_START;
        wr_data_d  = 8'h01;
        wr_start_d = 1'b1;
        state_d    = W_START_WAIT;
      end
      W_START_WAIT: begin
        if (wr_failure)      fail = 1'b1;
        else if (wr_done)    state_d = R_STAT;
        else if (wd_expired) fail = 1'b1;
        else                 wd_d = wd_q + WD_ONE;
      end
      R_STAT: begin
        owner_d    = 1'b0;
        rd_reg_d   = REG_INT_STATUS;
        rd_width_d = 4'd1;
        rd_start_d = 1'b1;
        state_d    = R_STAT_WAIT;
      end
      R_STAT_WAIT: begin
        if (rd_failure)      fail = 1'b1;
        else if (rd_done)    state_d = POP_STAT;
        else if (wd_expired) fail = 1'b1;
        else                 wd_d = wd_q + WD_ONE;
      end
      POP_STAT: begin
        if (pop_got) begin
          stat_d  = rd_fifo_data[2:0];
          state_d = CHK_STAT;
        end
      end
      CHK_STAT: begin
        if (stat_q != 3'd0) begin
          state_d = R_RANGE;
        end else begin
          poll_d = poll_q + 8'd1;
          if (poll_q + 8'd1 == POLL_MAX) fail = 1'b1;
          else                           state_d = R_STAT;
        end
      end
      R_RANGE: begin
        owner_d    = 1'b0;
        rd_reg_d   = REG_RANGE_RESULT;
        rd_width_d = 4'd2;
        rd_start_d = 1'b1;
        state_d    = R_RANGE_WAIT;
      end
      R_RANGE_WAIT: begin
        if (rd_failure)      fail = 1'b1;
        else if (rd_done)    state_d = POP_HI;
        else if (wd_expired) fail = 1'b1;
        else                 wd_d = wd_q + WD_ONE;
      end
      POP_HI: begin
        if (pop_got) begin
          hi_d    = rd_fifo_data;
          state_d = POP_LO;
        end
      end
      POP_LO: begin
        if (pop_got) begin
          lo_d    = rd_fifo_data;
          state_d = W_CLR;
        end
      end
      W_CLR: begin
        owner_d    = 1'b1;
        wr_reg_d   = REG_INT_CLEAR;
        wr_data_d  = 8'h01;
        wr_start_d = 1'b1;
        state_d    = W_CLR_WAIT;
      end
      W_CLR_WAIT: begin
        if (wr_failure)      fail = 1'b1;
        else if (wr_done)    state_d = PUBLISH;
        else if (wd_expired) fail = 1'b1;
        else                 wd_d = wd_q + WD_ONE;
      end
      PUBLISH: begin
        range_d       = {hi_q, lo_q};
        range_valid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      error_d = 1'b1;
      state_d = IDLE;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  assign busy            = busy_q;
  assign dev_address     = DEV_ADDR;
  assign rd_start        = rd_start_q;
  assign rd_reg_address  = rd_reg_q;
  assign rd_byte_width   = rd_width_q;
  assign rd_fifo_read_en = rd_pop_q;
  assign wr_start        = wr_start_q;
  assign wr_reg_address  = wr_reg_q;
  assign wr_data         = wr_data_q;
  assign i2c_owner       = owner_q;
  assign range_mm        = range_q;
  assign range_valid     = range_valid_q;
  assign error           = error_q;
  assign error_count     = err_cnt_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_tof_poll_sequencer.sv
// tb/tb_tof_poll_sequencer.sv - scoreboard bench for tof_poll_sequencer with modelled I2C engines
module tb_tof_poll_sequencer;

  localparam int POLL_LIMIT = 4;
  localparam int WATCHDOG   = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        busy;
  logic [6:0]  dev_address;
  logic        rd_start;
  logic [7:0]  rd_reg_address;
  logic [3:0]  rd_byte_width;
  logic        rd_done = 1'b0;
  logic        rd_failure = 1'b0;
  logic        rd_fifo_read_en;
  logic [7:0]  rd_fifo_data = 8'h00;
  logic        rd_fifo_empty = 1'b1;
  logic        rd_fifo_read_valid = 1'b0;
  logic        wr_start;
  logic [7:0]  wr_reg_address;
  logic [7:0]  wr_data;
  logic        wr_done = 1'b0;
  logic        wr_failure = 1'b0;
  logic        i2c_owner;
  logic [15:0] range_mm;
  logic        range_valid;
  logic        error;
  logic [7:0]  error_count;
  logic [3:0]  state_out;

  tof_poll_sequencer #(.POLL_LIMIT(POLL_LIMIT), .WATCHDOG(WATCHDOG)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .busy(busy), .dev_address(dev_address),
    .rd_start(rd_start), .rd_reg_address(rd_reg_address), .rd_byte_width(rd_byte_width),
    .rd_done(rd_done), .rd_failure(rd_failure), .rd_fifo_read_en(rd_fifo_read_en),
    .rd_fifo_data(rd_fifo_data), .rd_fifo_empty(rd_fifo_empty),
    .rd_fifo_read_valid(rd_fifo_read_valid), .wr_start(wr_start),
    .wr_reg_address(wr_reg_address), .wr_data(wr_data), .wr_done(wr_done),
    .wr_failure(wr_failure), .i2c_owner(i2c_owner), .range_mm(range_mm),
    .range_valid(range_valid), .error(error), .error_count(error_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model controls
  logic [7:0]  stat_script[$];
  logic [7:0]  fifo[$];
  logic [7:0]  range_hi = 8'h00, range_lo = 8'h00;
  bit          rd_fail_range = 0, rd_fail_all = 0, wr_hang = 0;
  bit          rd_pend = 0, wr_pend = 0, pop_flag = 0;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [3:0]  rd_w = 4'd0;

  // scoreboard
  logic [31:0] exp_wr[$], obs_wr[$], exp_rd[$], obs_rd[$], exp_range[$], obs_range[$];
  int pops = 0, bad_pops = 0, valid_pulses = 0, err_pulses = 0;
  int last_wr_cyc = 0, last_err_cyc = 0;
  logic err_busy = 1'b0;
  int checks = 0, errors = 0;

  // read engine + FIFO model: data appears one cycle after the pop strobe
  initial forever begin
    @(negedge clk);
    rd_done = 1'b0;
    rd_failure = 1'b0;
    rd_fifo_read_valid = 1'b0;
    if (pop_flag) begin
      rd_fifo_data = (fifo.size() > 0) ? fifo.pop_front() : 8'hEE;
      rd_fifo_read_valid = 1'b1;
      pop_flag = 0;
    end
    if (rd_fifo_read_en) begin
      pops++;
      if (fifo.size() == 0) bad_pops++;
      pop_flag = 1;
    end
    if (rd_start) begin
      obs_rd.push_back({19'b0, i2c_owner, rd_reg_address, rd_byte_width});
      rd_pend = 1;
      rd_cnt = 3;
      rd_w = rd_byte_width;
    end else if (rd_pend) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        rd_pend = 0;
        if (rd_fail_all || (rd_fail_range && rd_w == 4'd2)) begin
          rd_failure = 1'b1;
        end else begin
          rd_done = 1'b1;
          if (rd_w == 4'd1) begin
            fifo.push_back((stat_script.size() > 0) ? stat_script.pop_front() : 8'h00);
          end else begin
            fifo.push_back(range_hi);
            fifo.push_back(range_lo);
          end
        end
      end
    end
    rd_fifo_empty = (fifo.size() == 0);
  end

  // write engine model
  initial forever begin
    @(negedge clk);
    wr_done = 1'b0;
    wr_failure = 1'b0;
    if (wr_start) begin
      obs_wr.push_back({15'b0, i2c_owner, wr_reg_address, wr_data});
      last_wr_cyc = cyc;
      wr_pend = !wr_hang;
      wr_cnt = 3;
    end else if (wr_pend) begin
      wr_cnt--;
      if (wr_cnt == 0) begin
        wr_pend = 0;
        wr_done = 1'b1;
      end
    end
  end

  // output monitor
  initial forever begin
    @(negedge clk);
    if (range_valid) begin
      valid_pulses++;
      obs_range.push_back({16'b0, range_mm});
    end
    if (error) begin
      err_pulses++;
      last_err_cyc = cyc;
      err_busy = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_meas(input string tag, input int budget, input bit retrigger);
    int n;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
      trigger = (retrigger && n == 10);
    end
    trigger = 1'b0;
    check({tag, "/still_busy"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic sb(input string tag);
    check({tag, "/wr_n"}, obs_wr.size(), exp_wr.size());
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      check({tag, "/wr"}, obs_wr.pop_front(), exp_wr.pop_front());
    check({tag, "/rd_n"}, obs_rd.size(), exp_rd.size());
    while (obs_rd.size() > 0 && exp_rd.size() > 0)
      check({tag, "/rd"}, obs_rd.pop_front(), exp_rd.pop_front());
    check({tag, "/range_n"}, obs_range.size(), exp_range.size());
    while (obs_range.size() > 0 && exp_range.size() > 0)
      check({tag, "/range"}, obs_range.pop_front(), exp_range.pop_front());
    obs_wr.delete(); exp_wr.delete(); obs_rd.delete();
    exp_rd.delete(); obs_range.delete(); exp_range.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "/busy"}, {31'b0, busy}, 32'd0);
    check({tag, "/state"}, {28'b0, state_out}, 32'd0);
    check({tag, "/range_mm"}, {16'b0, range_mm}, 32'd0);
    check({tag, "/err_cnt"}, {24'b0, error_count}, 32'd0);
    check({tag, "/pulses"}, {27'b0, rd_start, wr_start, rd_fifo_read_en, range_valid, error}, 32'd0);
    check({tag, "/owner"}, {31'b0, i2c_owner}, 32'd0);
  endtask

  localparam logic [31:0] WR_START = {15'b0, 1'b1, 8'h00, 8'h01};
  localparam logic [31:0] WR_CLR   = {15'b0, 1'b1, 8'h0B, 8'h01};
  localparam logic [31:0] RD_STAT  = {19'b0, 1'b0, 8'h13, 4'd1};
  localparam logic [31:0] RD_RANGE = {19'b0, 1'b0, 8'h1E, 4'd2};

  initial begin
    int n, p0, e0, v0;

    // reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check("reset/dev_addr", {25'b0, dev_address}, 32'h29);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: immediate status, range 0x012C
    stat_script = '{8'h07};
    range_hi = 8'h01; range_lo = 8'h2C;
    exp_wr.push_back(WR_START); exp_wr.push_back(WR_CLR);
    exp_rd.push_back(RD_STAT);  exp_rd.push_back(RD_RANGE);
    exp_range.push_back(32'h012C);
    run_meas("t1", 200, 0);
    sb("t1");
    check("t1/range_mm", {16'b0, range_mm}, 32'h012C);
    check("t1/valid_pulses", valid_pulses, 1);
    check("t1/err_cnt", {24'b0, error_count}, 32'd0);

    // 2: three empty polls then ready
    stat_script = '{8'h00, 8'h00, 8'h00, 8'h04};
    range_hi = 8'h0B; range_lo = 8'hB8;
    exp_wr.push_back(WR_START);
    repeat (4) exp_rd.push_back(RD_STAT);
    exp_rd.push_back(RD_RANGE);
    exp_wr.push_back(WR_CLR);
    exp_range.push_back(32'h0BB8);
    run_meas("t2", 400, 0);
    sb("t2");
    check("t2/err_pulses", err_pulses, 0);

    // 3: poll exhaustion
    stat_script = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_wr.push_back(WR_START);
    repeat (POLL_LIMIT) exp_rd.push_back(RD_STAT);
    run_meas("t3", 400, 0);
    sb("t3");
    check("t3/err_pulses", err_pulses, 1);
    check("t3/err_cnt", {24'b0, error_count}, 32'd1);
    check("t3/range_kept", {16'b0, range_mm}, 32'h0BB8);

    // 4: read failure on range read
    stat_script = '{8'h01};
    rd_fail_range = 1;
    p0 = pops;
    exp_wr.push_back(WR_START);
    exp_rd.push_back(RD_STAT); exp_rd.push_back(RD_RANGE);
    run_meas("t4", 200, 0);
    rd_fail_range = 0;
    sb("t4");
    check("t4/err_pulses", err_pulses, 2);
    check("t4/idle_at_error", {31'b0, err_busy}, 32'd0);
    check("t4/pops", pops - p0, 1);
    check("t4/range_kept", {16'b0, range_mm}, 32'h0BB8);
    check("t4/err_cnt", {24'b0, error_count}, 32'd2);

    // 5: write engine hangs; watchdog fires, retrigger during busy ignored
    wr_hang = 1;
    exp_wr.push_back(WR_START);
    run_meas("t5", 300, 1);
    repeat (5) @(negedge clk);
    wr_hang = 0;
    wr_pend = 0;
    sb("t5");
    check("t5/wd_latency", last_err_cyc - last_wr_cyc, WATCHDOG);
    check("t5/err_cnt", {24'b0, error_count}, 32'd3);
    check("t5/no_requeue", {31'b0, busy}, 32'd0);

    // 6: async reset while in POP_HI, then a clean measurement
    stat_script = '{8'h01};
    range_hi = 8'h12; range_lo = 8'h34;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    n = 0;
    while (state_out != 4'd9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6/reach_pop_hi", {28'b0, state_out}, 32'd9);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    fifo.delete(); stat_script.delete();
    pop_flag = 0; rd_pend = 0; wr_pend = 0;
    obs_wr.delete(); obs_rd.delete(); obs_range.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stat_script = '{8'h05};
    range_hi = 8'h00; range_lo = 8'h64;
    exp_wr.push_back(WR_START); exp_wr.push_back(WR_CLR);
    exp_rd.push_back(RD_STAT);  exp_rd.push_back(RD_RANGE);
    exp_range.push_back(32'h0064);
    run_meas("t6", 200, 0);
    sb("t6");
    check("t6/err_cnt", {24'b0, error_count}, 32'd0);

    // 7: error_count saturation
    rd_fail_all = 1;
    e0 = err_pulses;
    v0 = valid_pulses;
    for (int i = 0; i < 255; i++) run_meas("t7", 200, 0);
    check("t7/err_cnt_255", {24'b0, error_count}, 32'hFF);
    for (int i = 0; i < 5; i++) run_meas("t7", 200, 0);
    check("t7/err_cnt_sat", {24'b0, error_count}, 32'hFF);
    check("t7/err_pulses", err_pulses - e0, 260);
    check("t7/no_valid", valid_pulses - v0, 0);
    check("t7/range_kept", {16'b0, range_mm}, 32'h0064);
    rd_fail_all = 0;
    obs_wr.delete(); obs_rd.delete(); obs_range.delete();

    check("bad_pops", bad_pops, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
